// File: rtl/branch_pkg.sv
// Shared constants and the execute-stage record for branch resolution.
package branch_pkg;

  // Taken codes driven back to the fetch-stage predictor.
  localparam logic [1:0] TAKEN_NT   = 2'b00;
  localparam logic [1:0] TAKEN_T    = 2'b01;
  localparam logic [1:0] TAKEN_IDLE = 2'b10;

  // Branch opcodes (instruction[31:26]).
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  // REGIMM sub-selectors (instruction[20:16]).
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // Contents of the execute-stage register.
  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        pred;
  } br_ex_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator. legal=0 means the opcode /
// rt_field pair is not a conditional branch; cond is then meaningless (0).
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        cond,
  output logic        legal
);

  // Decode the branch kind and evaluate its signed comparison.
  always_comb begin
    cond  = 1'b0;
    legal = 1'b0;
    case (opcode)
      OP_BEQ: begin
        legal = 1'b1;
        cond  = (rs == rt);
      end
      OP_BNE: begin
        legal = 1'b1;
        cond  = (rs != rt);
      end
      OP_BLEZ: begin
        legal = 1'b1;
        cond  = ($signed(rs) <= 32'sd0);
      end
      OP_BGTZ: begin
        legal = 1'b1;
        cond  = ($signed(rs) > 32'sd0);
      end
      OP_REGIMM: begin
        if (rt_field == RT_BLTZ) begin
          legal = 1'b1;
          cond  = rs[31];
        end else if (rt_field == RT_BGEZ) begin
          legal = 1'b1;
          cond  = ~rs[31];
        end
      end
      default: begin
        cond  = 1'b0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: captures a branch from decode, resolves
// it one edge later, and reports taken/mispredict plus saturating stats.
//
// Handshake: there is no backpressure toward decode. dec_valid=1 offers a
// branch; it is accepted at the next edge unless stall or flush is high.
// An accepted branch produces exactly one non-idle taken code, registered
// at the first edge where it sits in EX with stall=0 and flush=0; taken is
// TAKEN_IDLE (and mispredict 0) on every other cycle.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit EN_STATS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [5:0]       dec_opcode,
  input  logic [4:0]       dec_rt_field,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             dec_pred,
  input  logic             stall,
  input  logic             flush,
  input  logic             stats_clr,
  output logic [1:0]       taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] misp_count
);

  br_ex_t ex_q;
  logic   cond;
  logic   legal;
  logic   fire;

  // EX stage register: flush kills, stall holds, otherwise load from decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q.valid <= 1'b0;
    end else if (!stall) begin
      ex_q <= '{valid:    dec_valid,
                opcode:   dec_opcode,
                rt_field: dec_rt_field,
                rs:       rs_val,
                rt:       rt_val,
                pred:     dec_pred};
    end
  end

  branch_cond_eval u_cond (
    .opcode   (ex_q.opcode),
    .rt_field (ex_q.rt_field),
    .rs       (ex_q.rs),
    .rt       (ex_q.rt),
    .cond     (cond),
    .legal    (legal)
  );

  // A non-branch in EX is treated as an empty slot.
  assign fire = ex_q.valid & ~stall & ~flush & legal;

  // Resolution output register, idle unless a branch fires this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken      <= TAKEN_IDLE;
      mispredict <= 1'b0;
    end else if (fire) begin
      taken      <= {1'b0, cond};
      mispredict <= (cond != ex_q.pred);
    end else begin
      taken      <= TAKEN_IDLE;
      mispredict <= 1'b0;
    end
  end

  if (EN_STATS) begin : g_stats
    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        br_count   <= '0;
        misp_count <= '0;
      end else if (stats_clr) begin
        br_count   <= '0;
        misp_count <= '0;
      end else if (fire) begin
        if (br_count != '1) br_count <= br_count + 1'b1;
        if ((cond != ex_q.pred) && (misp_count != '1)) misp_count <= misp_count + 1'b1;
      end
    end
  end else begin : g_no_stats
    assign br_count   = '0;
    assign misp_count = '0;
  end

endmodule
